if_id_queue: RTL and testbench

- Parametrised successor to the single-entry IF/ID pipeline register.
- Holds a DEPTH-entry PC/instruction queue between fetch and decode, with an output register that presents one instruction to ID.
- Absorbs decode-side stalls without stalling fetch until the queue is full.
- Supports pipeline flush, bubble insertion, and 1-cycle bypass when the queue is empty.

---
 rtl/if_id_queue_pkg.sv | 36 +++
 rtl/if_id_queue_mem.sv | 26 ++
 rtl/if_id_queue.sv | 157 +++++++++++++++
 tb/tb_if_id_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants and output-select helper for the IF/ID instruction queue.
package if_id_queue_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        Stop         = 1'b1;
  localparam logic        NoStop       = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam int unsigned InstAddrBusW = 32;
  localparam int unsigned InstBusW     = 32;
  localparam int unsigned IfIdQDepth   = 4;
  localparam int unsigned StallIdBit   = 2;

  typedef enum logic [2:0] {
    OutFlush,
    OutHold,
    OutPop,
    OutBypass,
    OutBubble
  } out_sel_e;

  // Priority-ordered choice of what the ID output register loads this cycle.
  function automatic out_sel_e out_sel(input logic flush, input logic advance,
                                       input logic empty, input logic push);
    if (flush) begin
      return OutFlush;
    end else if (!advance) begin
      return OutHold;
    end else if (!empty) begin
      return OutPop;
    end else if (push) begin
      return OutBypass;
    end
    return OutBubble;
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// Register-array storage for the IF/ID queue: one synchronous write port, one async read port.
module if_id_queue_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; only the pointers in the parent are.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue with registered ID output, flush, bubble insertion and empty bypass.
// Optional performance counters are enabled by defining IF_ID_QUEUE_PERF_EN.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = InstAddrBusW,
  parameter int unsigned INST_W = InstBusW,
  parameter int unsigned DEPTH  = IfIdQDepth,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [5:0]        stall,
  input  logic              flush,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic [CNT_W-1:0]  count
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       full_cnt,
  output logic [CNT_W-1:0]  high_water
`endif
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned EntryW = ADDR_W + INST_W;

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic [INST_W-1:0] id_inst_q, id_inst_d;
  logic              id_valid_q, id_valid_d;

  logic              push, advance, empty, full;
  logic              pop, bypass, wr_en;
  out_sel_e          sel;
  logic [EntryW-1:0] head;

  // Only stall[2] matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1:0]};

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign if_ready = !full;
  assign push     = if_valid && if_ready && !flush;
  assign advance  = (stall[StallIdBit] == NoStop);

  assign sel    = out_sel(flush, advance, empty, push);
  assign pop    = (sel == OutPop);
  assign bypass = (sel == OutBypass);
  assign wr_en  = push && !bypass;

  if_id_queue_mem #(
    .DEPTH(DEPTH),
    .WIDTH(EntryW)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_en),
    .waddr_i(wr_ptr_q),
    .wdata_i({if_pc, if_inst}),
    .raddr_i(rd_ptr_q),
    .rdata_o(head)
  );

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    unique case (sel)
      OutFlush, OutBubble: begin
        id_pc_d    = '0;
        id_inst_d  = '0;
        id_valid_d = 1'b0;
      end
      OutHold: ;
      OutPop: begin
        id_pc_d    = head[EntryW-1:INST_W];
        id_inst_d  = head[INST_W-1:0];
        id_valid_d = 1'b1;
      end
      OutBypass: begin
        id_pc_d    = if_pc;
        id_inst_d  = if_inst;
        id_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      id_pc_q    <= ADDR_W'(ZeroWord);
      id_inst_q  <= INST_W'(ZeroWord);
      id_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc    = id_pc_q;
  assign id_inst  = id_inst_q;
  assign id_valid = id_valid_q;
  assign count    = count_q;

`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0]      bubble_cnt_q, full_cnt_q;
  logic [CNT_W-1:0] high_water_q, high_water_d;

  // Tracks count_d so the mark never lags the occupancy it describes.
  assign high_water_d = (count_d > high_water_q) ? count_d : high_water_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      bubble_cnt_q <= '0;
      full_cnt_q   <= '0;
      high_water_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_q + 32'(sel == OutBubble);
      full_cnt_q   <= full_cnt_q + 32'(full);
      high_water_q <= high_water_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign full_cnt   = full_cnt_q;
  assign high_water = high_water_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: driver queues expected ID entries, monitor checks each load.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      if_pc, if_inst;
  logic             if_valid;
  logic             if_ready;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      id_pc, id_inst;
  logic             id_valid;
  logic [CNT_W-1:0] count;
`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0]      bubble_cnt, full_cnt;
  logic [CNT_W-1:0] high_water;
`endif

  if_id_queue #(
    .ADDR_W(32),
    .INST_W(32),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .if_pc   (if_pc),
    .if_inst (if_inst),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .stall   (stall),
    .flush   (flush),
    .id_pc   (id_pc),
    .id_inst (id_inst),
    .id_valid(id_valid),
    .count   (count)
`ifdef IF_ID_QUEUE_PERF_EN
    ,
    .bubble_cnt(bubble_cnt),
    .full_cnt  (full_cnt),
    .high_water(high_water)
`endif
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic        mon_adv;
  logic [63:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic accept);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    if (accept) exp_q.push_back({pc, inst});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: after every edge where the output register was free to load, check what it took.
  initial begin
    forever begin
      @(posedge clk);
      mon_adv = !rst && !flush && !stall[2];
      #1;
      if (mon_adv) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("id_valid on load", {63'd0, id_valid}, 64'd1);
          chk("id order", {id_pc, id_inst}, mon_e);
        end else begin
          chk("id bubble", {63'd0, id_valid}, 64'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    if_valid = 1'b1;
    if_pc    = 32'hDEAD;
    if_inst  = 32'hBEEF;
    stall    = '0;
    flush    = 1'b0;
    step();
    step();
    chk("reset id_valid", {63'd0, id_valid}, 64'd0);
    chk("reset id_pc", {32'd0, id_pc}, 64'd0);
    chk("reset id_inst", {32'd0, id_inst}, 64'd0);
    chk("reset count", {61'd0, count}, 64'd0);
    chk("reset if_ready", {63'd0, if_ready}, 64'd1);
    rst      = 1'b0;
    if_valid = 1'b0;
    step();

    // Bypass into an empty queue
    drive(1'b1, 32'h100, 32'h3C01_0001, 1'b1);
    step();
    chk("bypass id_pc", {32'd0, id_pc}, 64'h100);
    chk("bypass id_inst", {32'd0, id_inst}, 64'h3C01_0001);
    chk("bypass id_valid", {63'd0, id_valid}, 64'd1);
    chk("bypass count", {61'd0, count}, 64'd0);
    if_valid = 1'b0;
    step();
    chk("bubble after bypass", {63'd0, id_valid}, 64'd0);

    // Fill under stall; fifth push is rejected
    stall = 6'b000100;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        chk("full if_ready", {63'd0, if_ready}, 64'd0);
        chk("full count", {61'd0, count}, 64'd4);
      end
      drive(1'b1, 32'(i * 4), 32'h2000_0000 | 32'(i * 4), i < 4);
      step();
    end
    chk("fifth rejected count", {61'd0, count}, 64'd4);
    chk("held bubble under stall", {63'd0, id_valid}, 64'd0);
`ifdef IF_ID_QUEUE_PERF_EN
    chk("high_water", {61'd0, high_water}, 64'd4);
`endif
    stall    = '0;
    if_valid = 1'b0;
    step();
    chk("drain count", {61'd0, count}, 64'd3);
    chk("ready after pop", {63'd0, if_ready}, 64'd1);
`ifdef IF_ID_QUEUE_PERF_EN
    chk("full_cnt", {32'd0, full_cnt}, 64'd2);
`endif
    step();
    step();
    step();
    chk("drained count", {61'd0, count}, 64'd0);
    step();
    chk("bubble after drain", {63'd0, id_valid}, 64'd0);

    // Simultaneous push and pop at count 2, wrapping pointers
    stall = 6'b000100;
    drive(1'b1, 32'h200, 32'hA000_0200, 1'b1);
    step();
    drive(1'b1, 32'h204, 32'hA000_0204, 1'b1);
    step();
    chk("pre-stream count", {61'd0, count}, 64'd2);
    stall = '0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h208 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1);
      step();
      chk("stream count", {61'd0, count}, 64'd2);
    end
    if_valid = 1'b0;
    step();
    chk("stream drain1", {61'd0, count}, 64'd1);
    step();
    chk("stream drain0", {61'd0, count}, 64'd0);
    step();

    // Flush mid-stream, outranking stall, with a push that must be dropped
    drive(1'b1, 32'h300, 32'h1111_1111, 1'b1);
    step();
    chk("pre-flush id_valid", {63'd0, id_valid}, 64'd1);
    stall = 6'b000100;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'h300 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b1);
      step();
    end
    chk("pre-flush count", {61'd0, count}, 64'd3);
    flush = 1'b1;
    drive(1'b1, 32'hBAD, 32'hBAD0_BAD0, 1'b0);
    exp_q.delete();
    step();
    chk("flush count", {61'd0, count}, 64'd0);
    chk("flush id_valid", {63'd0, id_valid}, 64'd0);
    chk("flush id_inst", {32'd0, id_inst}, 64'd0);
    chk("flush id_pc", {32'd0, id_pc}, 64'd0);
    flush    = 1'b0;
    stall    = '0;
    if_valid = 1'b0;
    step();
    step();
    drive(1'b1, 32'h400, 32'h2222_2222, 1'b1);
    step();
    if_valid = 1'b0;
    step();
    step();
    chk("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
